// File: rtl/flag_pkg.sv
// flag_pkg: shared types and helpers for the NZCV flag unit.
//   cond_e    - 4-bit condition code (EQ..NV)
//   FLAG_*    - bit positions of Z/N/C/V inside a {Z,N,C,V} nibble
//   cond_eval - evaluates a condition code against a flag nibble
package flag_pkg;

    typedef enum logic [3:0] {
        CondEq = 4'h0,
        CondNe = 4'h1,
        CondCs = 4'h2,
        CondCc = 4'h3,
        CondMi = 4'h4,
        CondPl = 4'h5,
        CondVs = 4'h6,
        CondVc = 4'h7,
        CondHi = 4'h8,
        CondLs = 4'h9,
        CondGe = 4'hA,
        CondLt = 4'hB,
        CondGt = 4'hC,
        CondLe = 4'hD,
        CondAl = 4'hE,
        CondNv = 4'hF
    } cond_e;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    function automatic logic cond_eval(input cond_e c, input logic [3:0] f);
        logic z;
        logic n;
        logic cy;
        logic v;
        logic r;
        z  = f[FLAG_Z];
        n  = f[FLAG_N];
        cy = f[FLAG_C];
        v  = f[FLAG_V];
        case (c)
            CondEq:  r = z;
            CondNe:  r = ~z;
            CondCs:  r = cy;
            CondCc:  r = ~cy;
            CondMi:  r = n;
            CondPl:  r = ~n;
            CondVs:  r = v;
            CondVc:  r = ~v;
            CondHi:  r = cy & ~z;
            CondLs:  r = ~cy | z;
            CondGe:  r = (n == v);
            CondLt:  r = (n != v);
            CondGt:  r = ~z & (n == v);
            CondLe:  r = z | (n != v);
            CondAl:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// flag_stack: DEPTH-entry LIFO of 4-bit flag sets.
//   i_clk, i_rst_n    - clock, async active-low reset (clears count only)
//   i_push, i_pop     - push i_din / pop top; both together is an error
//   i_din             - flag set to save
//   o_top             - entry at the top of the stack (0 when empty)
//   o_count           - occupied entries
//   o_full, o_empty   - occupancy status
//   o_pop_ok          - this cycle's pop is accepted
//   o_err             - single-cycle overflow/underflow/conflict pulse
module flag_stack
    import flag_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [3:0]    i_din,
    output logic [3:0]    o_top,
    output logic [PW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_pop_ok,
    output logic          o_err
);

    logic [PW-1:0] r_count;
    logic [3:0]    r_mem [DEPTH];
    logic          w_push_ok;

    assign o_full    = (r_count == PW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~i_pop & ~o_full;
    assign o_pop_ok  = i_pop & ~i_push & ~o_empty;
    assign o_err     = (i_push & i_pop) | (i_push & ~i_pop & o_full) |
                       (i_pop & ~i_push & o_empty);
    assign o_count   = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (w_push_ok) begin
            r_count <= r_count + PW'(1);
        end else if (o_pop_ok) begin
            r_count <= r_count - PW'(1);
        end
    end

    // Storage needs no reset: entries above the count are never read.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_push_ok && r_count == PW'(i)) begin
                r_mem[i] <= i_din;
            end
        end
    end

    // Mux by comparison instead of r_mem[r_count-1] to keep index widths exact.
    always_comb begin
        o_top = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_count == PW'(i + 1)) begin
                o_top = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: registered NZCV flags decoded from carry-save vectors, condition
// evaluation and a save/restore stack for interrupt entry/exit.
//   i_clk, i_rst_n       - clock, async active-low reset
//   i_in_valid           - i_sin/i_cin/i_set_mask valid
//   i_sin, i_cin         - W-bit sum and carry vectors
//   i_set_mask           - per-flag write enable {Z,N,C,V}
//   i_cond_valid, i_cond - condition evaluation request
//   i_push, i_pop        - save/restore flags
//   i_err_clr            - clear sticky error
//   o_flags              - architectural {Z,N,C,V}
//   o_cond_out_valid     - o_cond_true valid (one cycle after request)
//   o_cond_true          - condition result (holds when no request)
//   o_stack_count/full/empty - stack occupancy
//   o_err                - sticky over/underflow/conflict error
// Build option: define FLAG_FWD_EN to evaluate conditions on the next-state
// flags, removing the bubble between a flag update and a dependent branch.
module flag_unit
    import flag_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_in_valid,
    input  logic [W-1:0]  i_sin,
    input  logic [W-1:0]  i_cin,
    input  logic [3:0]    i_set_mask,
    input  logic          i_cond_valid,
    input  cond_e         i_cond,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_err_clr,
    output logic [3:0]    o_flags,
    output logic          o_cond_out_valid,
    output logic          o_cond_true,
    output logic [PW-1:0] o_stack_count,
    output logic          o_stack_full,
    output logic          o_stack_empty,
    output logic          o_err
);

    logic [3:0] r_flags;
    logic       r_cond_valid;
    logic       r_cond_true;
    logic       r_err;

    logic [3:0] w_dec;
    logic [3:0] w_upd;
    logic [3:0] w_flags_d;
    logic [3:0] w_cond_flags;
    logic [3:0] w_top;
    logic       w_pop_ok;
    logic       w_stack_err;

    flag_stack #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_stack (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_push   (i_push),
        .i_pop    (i_pop),
        .i_din    (r_flags),
        .o_top    (w_top),
        .o_count  (o_stack_count),
        .o_full   (o_stack_full),
        .o_empty  (o_stack_empty),
        .o_pop_ok (w_pop_ok),
        .o_err    (w_stack_err)
    );

    always_comb begin
        w_dec         = '0;
        w_dec[FLAG_Z] = (i_sin == '0);
        w_dec[FLAG_N] = i_sin[W-1];
        w_dec[FLAG_C] = i_cin[W-1];
        w_dec[FLAG_V] = i_cin[W-2] ^ i_cin[W-1];
    end

    assign w_upd     = i_in_valid ? ((r_flags & ~i_set_mask) | (w_dec & i_set_mask)) : r_flags;
    // An accepted pop restores the saved set and overrides any update.
    assign w_flags_d = w_pop_ok ? w_top : w_upd;

`ifdef FLAG_FWD_EN
    assign w_cond_flags = w_flags_d;
`else
    assign w_cond_flags = r_flags;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags      <= '0;
            r_cond_valid <= 1'b0;
            r_cond_true  <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_flags      <= w_flags_d;
            r_cond_valid <= i_cond_valid;
            if (i_cond_valid) begin
                r_cond_true <= cond_eval(i_cond, w_cond_flags);
            end
            // A new error beats a simultaneous clear.
            r_err <= w_stack_err | (r_err & ~i_err_clr);
        end
    end

    assign o_flags          = r_flags;
    assign o_cond_out_valid = r_cond_valid;
    assign o_cond_true      = r_cond_true;
    assign o_err            = r_err;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit (W=32, DEPTH=4). Expected snapshots are
// queued as each cycle is driven and compared with the captured outputs.
module tb_flag_unit;
    import flag_pkg::*;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  sin = '0;
    logic [W-1:0]  cin = '0;
    logic [3:0]    set_mask = '0;
    logic          cond_valid = 1'b0;
    cond_e         cond = CondEq;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [3:0]    flags;
    logic          cond_out_valid;
    logic          cond_true;
    logic [PW-1:0] stack_count;
    logic          stack_full;
    logic          stack_empty;
    logic          err;

    typedef struct packed {
        logic [3:0]    fl;
        logic [PW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          err;
        logic          cv;
        logic          ct;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    flag_unit #(.W(W), .DEPTH(DEPTH), .PW(PW)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_in_valid       (in_valid),
        .i_sin            (sin),
        .i_cin            (cin),
        .i_set_mask       (set_mask),
        .i_cond_valid     (cond_valid),
        .i_cond           (cond),
        .i_push           (push),
        .i_pop            (pop),
        .i_err_clr        (err_clr),
        .o_flags          (flags),
        .o_cond_out_valid (cond_out_valid),
        .o_cond_true      (cond_true),
        .o_stack_count    (stack_count),
        .o_stack_full     (stack_full),
        .o_stack_empty    (stack_empty),
        .o_err            (err)
    );

    always #5 clk = ~clk;

    function automatic snap_t sample();
        snap_t s;
        s.fl = flags; s.cnt = stack_count; s.full = stack_full; s.empty = stack_empty;
        s.err = err; s.cv = cond_out_valid; s.ct = cond_true;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("flags=%b cnt=%0d full=%b empty=%b err=%b cv=%b ct=%b",
                         s.fl, s.cnt, s.full, s.empty, s.err, s.cv, s.ct);
    endfunction

    task automatic set_idle();
        in_valid = 1'b0; set_mask = '0; cond_valid = 1'b0; cond = CondEq;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    // Drive one cycle. dv is the {Z,N,C,V} nibble the vectors should decode
    // to (Z and N never both set); expected post-edge state is queued.
    task automatic cyc(input logic iv, input logic [3:0] dv, input logic [3:0] mask,
                       input logic cv, input cond_e cnd, input logic ps, input logic pp,
                       input logic clr, input logic [3:0] efl, input logic [PW-1:0] ecnt,
                       input logic eerr, input logic ecv, input logic ect);
        snap_t e;
        in_valid = iv;
        if (iv) begin
            sin = dv[3] ? 32'h0 : (dv[2] ? 32'h8000_0000 : 32'h0000_0001);
            cin = {dv[1], dv[1] ^ dv[0], 30'b0};
        end else begin
            sin = $urandom;
            cin = $urandom;
        end
        set_mask = mask; cond_valid = cv; cond = cnd; push = ps; pop = pp; err_clr = clr;
        e.fl = efl; e.cnt = ecnt; e.full = (ecnt == PW'(DEPTH)); e.empty = (ecnt == '0);
        e.err = eerr; e.cv = ecv; e.ct = ect;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back(sample());
    endtask

    task automatic test_reset();
        snap_t e;
        snap_t o;
        int    k;
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = '0; e.empty = 1'b1;
        o = sample();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL reset_hold: got %s, want %s", fmt(o), fmt(e));
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_idle[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
            k++;
        end
    endtask

    task automatic test_decode();
        snap_t e;
        snap_t o;
        int    k;
        cyc(1, 4'hB, 4'hF, 0, CondEq, 0, 0, 0, 4'hB, 0, 0, 0, 0);
        cyc(0, 4'h0, 4'hF, 0, CondEq, 0, 0, 0, 4'hB, 0, 0, 0, 0);
        cyc(1, 4'h1, 4'hF, 0, CondEq, 0, 0, 0, 4'h1, 0, 0, 0, 0);
        cyc(1, 4'h6, 4'hF, 0, CondEq, 0, 0, 0, 4'h6, 0, 0, 0, 0);
        cyc(1, 4'h9, 4'h8, 0, CondEq, 0, 0, 0, 4'hE, 0, 0, 0, 0);
        cyc(1, 4'h0, 4'h0, 0, CondEq, 0, 0, 0, 4'hE, 0, 0, 0, 0);
        cyc(1, 4'hB, 4'hF, 0, CondEq, 0, 0, 0, 4'hB, 0, 0, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL decode[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
            k++;
        end
    endtask

    task automatic test_cond();
        snap_t       e;
        snap_t       o;
        int          k;
        logic [15:0] tbl_a;
        logic [15:0] tbl_b;
        tbl_a = 16'h6996;  // truth of each code for flags 4'b0110
        tbl_b = 16'h6A69;  // truth of each code for flags 4'b1001
        cyc(1, 4'h4, 4'h4, 0, CondEq, 0, 0, 0, 4'hF, 0, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 1, CondGe, 0, 0, 0, 4'hF, 0, 0, 1, 1);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 0, 0, 4'hF, 0, 0, 0, 1);
        cyc(0, 4'h0, 4'h0, 1, CondHi, 0, 0, 0, 4'hF, 0, 0, 1, 0);
        cyc(1, 4'h6, 4'hF, 0, CondEq, 0, 0, 0, 4'h6, 0, 0, 0, 0);
        for (int c = 0; c < 16; c++) begin
            cyc(0, 4'h0, 4'h0, 1, cond_e'(4'(c)), 0, 0, 0, 4'h6, 0, 0, 1, tbl_a[c]);
        end
        cyc(1, 4'h9, 4'hF, 0, CondEq, 0, 0, 0, 4'h9, 0, 0, 0, tbl_a[15]);
        for (int c = 0; c < 16; c++) begin
            cyc(0, 4'h0, 4'h0, 1, cond_e'(4'(c)), 0, 0, 0, 4'h9, 0, 0, 1, tbl_b[c]);
        end
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 0, 0, 4'h9, 0, 0, 0, tbl_b[15]);
        k = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL cond[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
            k++;
        end
    endtask

    task automatic test_stack();
        snap_t e;
        snap_t o;
        int    k;
        cyc(1, 4'h1, 4'hF, 0, CondEq, 0, 0, 0, 4'h1, 0, 0, 0, 0);
        cyc(1, 4'h2, 4'hF, 0, CondEq, 1, 0, 0, 4'h2, 1, 0, 0, 0);
        cyc(1, 4'h3, 4'hF, 0, CondEq, 1, 0, 0, 4'h3, 2, 0, 0, 0);
        cyc(1, 4'h4, 4'hF, 0, CondEq, 1, 0, 0, 4'h4, 3, 0, 0, 0);
        cyc(1, 4'h5, 4'hF, 0, CondEq, 1, 0, 0, 4'h5, 4, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 1, 0, 0, 4'h5, 4, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 1, 0, 4'h4, 3, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 1, 0, 4'h3, 2, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 1, 0, 4'h2, 1, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 1, 0, 4'h1, 0, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 1, 0, 4'h1, 0, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 0, 1, 4'h1, 0, 0, 0, 0);
        cyc(1, 4'h2, 4'hF, 0, CondEq, 0, 1, 0, 4'h2, 0, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 0, 1, 4'h2, 0, 0, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL stack[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
            k++;
        end
    endtask

    task automatic test_same_cycle();
        snap_t e;
        snap_t o;
        int    k;
        cyc(1, 4'h6, 4'hF, 0, CondEq, 0, 0, 0, 4'h6, 0, 0, 0, 0);
        cyc(1, 4'h3, 4'hF, 0, CondEq, 1, 0, 0, 4'h3, 1, 0, 0, 0);
        cyc(1, 4'h9, 4'hF, 0, CondEq, 0, 1, 0, 4'h6, 0, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 1, 0, 0, 4'h6, 1, 0, 0, 0);
        cyc(1, 4'h9, 4'hF, 0, CondEq, 1, 1, 0, 4'h9, 1, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 1, 1, 1, 4'h9, 1, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 0, 1, 4'h9, 1, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 1, 0, 4'h6, 0, 0, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL same_cycle[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
            k++;
        end
    endtask

    task automatic test_fwd();
        snap_t e;
        snap_t o;
        int    k;
        logic  fwd_ct;
`ifdef FLAG_FWD_EN
        fwd_ct = 1'b1;
`else
        fwd_ct = 1'b0;
`endif
        // Z goes 0->1 in the same cycle as the EQ request.
        cyc(1, 4'h9, 4'h8, 1, CondEq, 0, 0, 0, 4'hE, 0, 0, 1, fwd_ct);
        cyc(0, 4'h0, 4'h0, 1, CondNe, 0, 0, 0, 4'hE, 0, 0, 1, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL fwd[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
            k++;
        end
    endtask

    task automatic test_async_reset();
        snap_t e;
        snap_t o;
        int    k;
        cyc(0, 4'h0, 4'h0, 0, CondEq, 1, 0, 0, 4'hE, 1, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 1, 0, 0, 4'hE, 2, 0, 0, 0);
        cyc(0, 4'h0, 4'h0, 1, CondAl, 1, 0, 0, 4'hE, 3, 0, 1, 1);
        set_idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e = '0; e.empty = 1'b1;
        o = sample();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL async_reset: got %s, want %s", fmt(o), fmt(e));
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Stack must really be empty: a pop underflows and flags stay zero.
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 1, 0, 4'h0, 0, 1, 0, 0);
        cyc(0, 4'h0, 4'h0, 0, CondEq, 0, 0, 1, 4'h0, 0, 0, 0, 0);
        k = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL post_reset[%0d]: got %s, want %s", k, fmt(o), fmt(e));
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_cond();
        test_stack();
        test_same_cycle();
        test_fwd();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
